// File: rtl/repeat_tokens_pkg.sv
// Shared defaults and width helpers for the repeat_tokens block.
// The top level and the per-channel slice both import this package.
package repeat_tokens_pkg;

    localparam int DEFAULT_CHANNELS    = 2;
    localparam int DEFAULT_MAX_FACTOR  = 4;
    localparam int DEFAULT_MAX_PENDING = 200;

    function automatic int factor_width(input int max_factor);
        return $clog2(max_factor + 1);
    endfunction

    // The counter must hold a full MAX_PENDING plus one more burst, so the overflow compare never wraps.
    function automatic int pend_width(input int max_pending, input int max_factor);
        return $clog2(max_pending + max_factor + 1);
    endfunction

endpackage

// File: rtl/repeat_tokens_channel.sv
// One token channel: pending counter plus sticky overflow flag.
// Emits one output pulse per cycle while tokens are owed and the output is not held.
module repeat_tokens_channel
    import repeat_tokens_pkg::*;
#(
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int FACTOR_W    = factor_width(DEFAULT_MAX_FACTOR),
    parameter int PEND_W      = pend_width(DEFAULT_MAX_PENDING, DEFAULT_MAX_FACTOR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    input  logic [FACTOR_W-1:0] f,
    input  logic                hold,
    output logic                b,
    output logic [PEND_W-1:0]   pending,
    output logic                overflow
);

    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PENDING);

    logic [PEND_W-1:0] pending_q, pending_d;
    logic [PEND_W-1:0] add;
    logic [PEND_W-1:0] sum;
    logic              overflow_q, overflow_d;
    logic              tok;

    always_comb begin
        tok = a && (f != '0);
        add = tok ? PEND_W'(f) : '0;
        b   = (tok || (pending_q != '0)) && !hold && !overflow_q;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pending_d  = pending_q;
        overflow_d = overflow_q;
        sum        = pending_q + add - PEND_W'(b);
        if (!overflow_q) begin
            if (sum > PEND_LIMIT) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = sum;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/repeat_tokens.sv
// Multi-channel token repeater: clamps the shared factor and fans it out to
// independent channel slices, then reduces their status to overflow_any/idle.
module repeat_tokens
    import repeat_tokens_pkg::*;
#(
    parameter int  CHANNELS    = DEFAULT_CHANNELS,
    parameter int  MAX_FACTOR  = DEFAULT_MAX_FACTOR,
    parameter int  MAX_PENDING = DEFAULT_MAX_PENDING,
    localparam int FACTOR_W    = factor_width(MAX_FACTOR),
    localparam int PEND_W      = pend_width(MAX_PENDING, MAX_FACTOR)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        a,
    input  logic [FACTOR_W-1:0]        factor,
    input  logic                       hold,
    output logic [CHANNELS-1:0]        b,
    output logic [CHANNELS*PEND_W-1:0] pending,
    output logic [CHANNELS-1:0]        overflow,
    output logic                       overflow_any,
    output logic                       idle
);

    localparam logic [FACTOR_W-1:0] MAX_F = FACTOR_W'(MAX_FACTOR);

    logic [FACTOR_W-1:0] f_eff;
    logic [CHANNELS-1:0] pend_nz;

    assign f_eff = (factor > MAX_F) ? MAX_F : factor;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        repeat_tokens_channel #(
            .MAX_PENDING (MAX_PENDING),
            .FACTOR_W    (FACTOR_W),
            .PEND_W      (PEND_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .a        (a[i]),
            .f        (f_eff),
            .hold     (hold),
            .b        (b[i]),
            .pending  (pending[i*PEND_W +: PEND_W]),
            .overflow (overflow[i])
        );
        assign pend_nz[i] = |pending[i*PEND_W +: PEND_W];
    end

    assign overflow_any = |overflow;
    assign idle         = ~|pend_nz && ~|a;

endmodule

// File: tb/tb_repeat_tokens.sv
// Scoreboarded bench for repeat_tokens with default parameters (2 channels,
// factor up to 4, 200 pending): per-cycle expectations plus directed checks.
module tb_repeat_tokens;
    import repeat_tokens_pkg::*;

    localparam int CH     = 2;
    localparam int MAXF   = 4;
    localparam int MAXP   = 200;
    localparam int FW     = factor_width(MAXF);
    localparam int PEND_W = pend_width(MAXP, MAXF);

    typedef struct packed {
        logic [CH-1:0]        b;
        logic [CH*PEND_W-1:0] pend;
        logic [CH-1:0]        ovf;
        logic                 ovf_any;
        logic                 idle;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH-1:0]        a;
    logic [FW-1:0]        factor;
    logic                 hold;
    logic [CH-1:0]        b;
    logic [CH*PEND_W-1:0] pending;
    logic [CH-1:0]        overflow;
    logic                 overflow_any;
    logic                 idle;

    int      n_tests = 0;
    int      n_fail  = 0;
    exp_t    sb[$];
    int      mp[CH];
    bit      mov[CH];
    logic [CH-1:0] last_b;

    repeat_tokens dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .factor       (factor),
        .hold         (hold),
        .b            (b),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_any (overflow_any),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_factor();
        return (int'(factor) > MAXF) ? MAXF : int'(factor);
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   f;
        bit   tok;
        e = '0;
        f = eff_factor();
        for (int i = 0; i < CH; i++) begin
            tok     = a[i] && (f > 0);
            e.b[i]  = (tok || mp[i] != 0) && !hold && !mov[i];
            e.pend[i*PEND_W +: PEND_W] = PEND_W'(mp[i]);
            e.ovf[i] = mov[i];
        end
        e.ovf_any = |e.ovf;
        e.idle    = (mp[0] == 0) && (mp[1] == 0) && (a == '0);
        return e;
    endfunction

    task automatic model_update(input logic [CH-1:0] eb);
        int f;
        int nxt;
        f = eff_factor();
        for (int i = 0; i < CH; i++) begin
            if (!mov[i]) begin
                nxt = mp[i] + ((a[i] && f > 0) ? f : 0) - int'(eb[i]);
                if (nxt > MAXP) mov[i] = 1'b1;
                else            mp[i]  = nxt;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mp[i]  = 0;
            mov[i] = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input logic [CH-1:0] a_v,
                        input logic [FW-1:0] f_v, input logic h_v);
        exp_t e;
        logic [CH-1:0] eb;
        a      = a_v;
        factor = f_v;
        hold   = h_v;
        e      = model_expect();
        eb     = e.b;
        sb.push_back(e);
        #3;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_b"},        64'(b),            64'(e.b));
            check({tag, "_pending"},  64'(pending),      64'(e.pend));
            check({tag, "_overflow"}, 64'(overflow),     64'(e.ovf));
            check({tag, "_ovf_any"},  64'(overflow_any), 64'(e.ovf_any));
            check({tag, "_idle"},     64'(idle),         64'(e.idle));
        end
        last_b = b;
        @(posedge clk);
        model_update(eb);
        @(negedge clk);
    endtask

    task automatic async_reset_pulse();
        a = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_pending",  64'(pending),      64'd0);
        check("rst_mid_overflow", 64'(overflow),     64'd0);
        check("rst_mid_ovf_any",  64'(overflow_any), 64'd0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        string a_s;
        string b_s;
        int    pulses;

        rst    = 1'b1;
        a      = '0;
        factor = '0;
        hold   = 1'b0;
        model_reset();
        #12;
        check("reset_pending",  64'(pending),      64'd0);
        check("reset_overflow", 64'(overflow),     64'd0);
        check("reset_ovf_any",  64'(overflow_any), 64'd0);
        check("reset_idle",     64'(idle),         64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Doubling pattern on channel 0.
        a_s = "10010011000110100001100100";
        b_s = "11011011110111111001111110";
        for (int j = 0; j < a_s.len(); j++) begin
            step("dbl", {1'b0, a_s[j] == "1"}, 3'd2, 1'b0);
            check($sformatf("dbl_lit%0d", j), 64'(last_b[0]), 64'(b_s[j] == "1"));
        end
        repeat (3) step("dbl_drain", 2'b00, 3'd2, 1'b0);

        // Factor 3: one token gives three pulses.
        step("f3", 2'b01, 3'd3, 1'b0);
        check("f3_pend_after1", 64'(pending[PEND_W-1:0]), 64'd2);
        step("f3", 2'b00, 3'd3, 1'b0);
        check("f3_pend_after2", 64'(pending[PEND_W-1:0]), 64'd1);
        step("f3", 2'b00, 3'd3, 1'b0);
        check("f3_pend_after3", 64'(pending[PEND_W-1:0]), 64'd0);
        step("f3", 2'b00, 3'd3, 1'b0);
        check("f3_tail_b", 64'(last_b[0]), 64'd0);

        // Factor 0 discards tokens.
        step("f0", 2'b01, 3'd0, 1'b0);
        check("f0_b", 64'(last_b[0]), 64'd0);
        check("f0_pend", 64'(pending[PEND_W-1:0]), 64'd0);

        // Factor above MAX_FACTOR clamps to 4 pulses.
        pulses = 0;
        step("clamp", 2'b01, 3'd7, 1'b0);
        pulses += int'(last_b[0]);
        for (int j = 0; j < 7; j++) begin
            step("clamp", 2'b00, 3'd7, 1'b0);
            pulses += int'(last_b[0]);
        end
        check("clamp_pulses", 64'(pulses), 64'd4);

        // Factor change mid-stream only affects newly arriving tokens: 2 + 4 = 6 pulses.
        pulses = 0;
        step("fchg", 2'b01, 3'd2, 1'b0);
        pulses += int'(last_b[0]);
        step("fchg", 2'b01, 3'd4, 1'b0);
        pulses += int'(last_b[0]);
        for (int j = 0; j < 8; j++) begin
            step("fchg", 2'b00, 3'd1, 1'b0);
            pulses += int'(last_b[0]);
        end
        check("fchg_pulses", 64'(pulses), 64'd6);

        // Hold accumulates on channel 1, then drains.
        for (int j = 0; j < 3; j++) begin
            step("hold", 2'b10, 3'd4, 1'b1);
            check("hold_b", 64'(last_b), 64'd0);
        end
        check("hold_pend12", 64'(pending[PEND_W +: PEND_W]), 64'd12);
        for (int j = 0; j < 12; j++) begin
            step("drain", 2'b00, 3'd4, 1'b0);
            check("drain_b1", 64'(last_b[1]), 64'd1);
        end
        #3 check("drain_idle", 64'(idle), 64'd1);
        @(negedge clk);

        // Channel 0 fills to the limit while channel 1 keeps working.
        for (int j = 0; j < 200; j++) begin
            step("fill", {1'((j % 2) == 0), 1'b1}, 3'd2, 1'b0);
        end
        check("fill_pend200", 64'(pending[PEND_W-1:0]), 64'd200);
        check("fill_no_ovf",  64'(overflow[0]), 64'd0);
        step("ovf", 2'b11, 3'd2, 1'b0);
        check("ovf_flag",    64'(overflow[0]),  64'd1);
        check("ovf_any",     64'(overflow_any), 64'd1);
        check("ovf_pend",    64'(pending[PEND_W-1:0]), 64'd200);
        step("ovf_after", 2'b01, 3'd2, 1'b0);
        check("ovf_b0",      64'(last_b[0]), 64'd0);
        check("ovf_ch1_b",   64'(last_b[1]), 64'd1);
        check("ovf_ch1_ovf", 64'(overflow[1]), 64'd0);

        // Sticky overflow ignores further tokens.
        for (int j = 0; j < 50; j++) begin
            step("sticky", {1'b0, 1'(j % 2)}, 3'd2, 1'b0);
        end
        check("sticky_flag", 64'(overflow[0]), 64'd1);
        check("sticky_pend", 64'(pending[PEND_W-1:0]), 64'd200);

        // Asynchronous reset mid-cycle, then normal doubling again.
        async_reset_pulse();
        step("post_rst", 2'b01, 3'd2, 1'b0);
        check("post_rst_b0", 64'(last_b[0]), 64'd1);
        step("post_rst", 2'b00, 3'd2, 1'b0);
        check("post_rst_b1", 64'(last_b[0]), 64'd1);
        step("post_rst", 2'b00, 3'd2, 1'b0);
        check("post_rst_b2", 64'(last_b[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/repeat_tokens.md
REPEAT_TOKENS -- requirements
Module: repeat_tokens

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent serial token channels.
REQ-002 Parameter MAX_FACTOR, default 4: largest supported repeat factor.
REQ-003 Parameter MAX_PENDING, default 200: largest legal pending-token count per channel.
REQ-004 Derived FACTOR_W = $clog2(MAX_FACTOR+1); PEND_W = $clog2(MAX_PENDING+MAX_FACTOR+1).
REQ-005 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port a  input  CHANNELS  token input; bit i belongs to channel i.
REQ-008 Port factor  input  FACTOR_W  repeat factor shared by all channels, sampled every cycle.
REQ-009 Port hold  input  1  output stall, shared by all channels.
REQ-010 Port b  output  CHANNELS  repeated token output, one bit per channel.
REQ-011 Port pending  output  CHANNELS*PEND_W  per-channel pending count, channel i in bits [i*PEND_W +: PEND_W].
REQ-012 Port overflow  output  CHANNELS  per-channel sticky overflow flag.
REQ-013 Port overflow_any  output  1  OR of all overflow bits.
REQ-014 Port idle  output  1  high when all pending counts are zero and no a bit is high.

Function
REQ-015 Effective factor F SHALL be min(factor, MAX_FACTOR); factor 0 SHALL discard incoming tokens.
REQ-016 Channel i add term SHALL be F when a[i]=1 and F>0, else 0.
REQ-017 b[i] SHALL be combinational: (a[i]&&F>0 || pending_i!=0) && !hold && !overflow[i]; zero latency from a.
REQ-018 Next pending_i SHALL be pending_i + add - b[i], computed at PEND_W width without wrap.
REQ-019 If next pending_i > MAX_PENDING, overflow[i] SHALL set on that edge and pending_i SHALL keep its current value.
REQ-020 overflow[i] SHALL be sticky; only rst clears it.
REQ-021 With overflow[i]=1, channel i SHALL ignore a[i], keep pending_i frozen and drive b[i]=0.
REQ-022 While hold=1, b SHALL be 0 on all channels, and incoming tokens SHALL still accumulate with overflow still checked.
REQ-023 Channels SHALL be fully independent; overflow on one SHALL not affect the others.
REQ-024 With F=2, hold=0, a single channel SHALL reproduce a=10010011 -> b=11011011.
REQ-025 A change of factor mid-stream SHALL affect only tokens arriving in that cycle; already pending tokens are unaffected.

Reset
REQ-026 On rst=1, all pending_i SHALL go to 0 and overflow to 0 asynchronously; b follows a per REQ-017.
REQ-027 Reset asserted mid-burst SHALL discard all pending tokens; the first edge after release SHALL behave as from power-up.

Structure
REQ-028 Package repeat_tokens_pkg SHALL hold the default constants (CHANNELS, MAX_FACTOR, MAX_PENDING) and the width-calculation functions.
REQ-029 Per-channel logic SHALL be a sub-module repeat_tokens_channel (one counter plus overflow flag), instantiated CHANNELS times in a generate loop.
REQ-030 Top level SHALL contain only factor clamping, the generate loop and the overflow_any/idle reductions.

Verification
REQ-031 F=2, ch0 a=10010011000110100001100100 -> b=11011011110111111001111110, overflow=0.
REQ-032 F=3, ch0 a=1 for one cycle then 0 -> b=111 then 0, pending 2,1,0; F=0 with a=1 -> b=0, pending stays 0.
REQ-033 F=2, ch0 a=1 for 200 cycles -> pending=200, overflow=0; cycle 201 with a=1 -> overflow[0]=1, overflow_any=1, b[0]=0, ch1 still operating normally.
REQ-034 F=4, ch1 a=1 for 3 cycles with hold=1 -> b=0, pending=12; hold released -> b[1]=1 for 12 cycles, then idle=1.
REQ-035 Overflow set, then a toggling for 50 cycles -> flag and pending unchanged; rst pulse mid-cycle -> pending=0 and overflow=0 immediately, then normal doubling resumes.
REQ-036 factor=7 with MAX_FACTOR=4, one token -> exactly 4 b pulses.
